// File: rtl/aes128_inv_key_expansion.sv
// Inverse AES-128 key schedule: loads the round-10 key and derives round 9..0 on request, one word op per cycle.
// Step latency 12 cycles (10 with AES128_INV_KEY_PARALLEL_XOR_EN); requests arriving mid-step are dropped, never queued.

// Byte-serial S-box substitution: one byte per cycle after a start cycle, done on the last byte.
module aes128_sub_bytes #(
    parameter int N_BYTES       = 4,
    parameter bit ENCRYPT       = 1'b1,
    parameter bit EXTERNAL_SBOX = 1'b0,
    localparam int IW           = (N_BYTES > 1) ? $clog2(N_BYTES) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   start_i,
    input  logic [8*N_BYTES-1:0]   data_i,
    output logic                   byte_valid_o,
    output logic [IW-1:0]          byte_idx_o,
    output logic [7:0]             byte_o,
    output logic                   done_o,
    output logic [7:0]             sbox_sub_o,
    input  logic [7:0]             sbox_sub_i
);
    logic [8*N_BYTES-1:0] data;
    logic                 busy;
    logic [IW-1:0]        idx;
    logic [IW-1:0]        idx_nxt;
    logic [7:0]           sub;
    logic                 last;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] i;
        i = gf_inv(x);
        return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
    endfunction

    assign last    = (idx == IW'(N_BYTES - 1));
    assign idx_nxt = idx + 1'b1;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            data <= '0;
            busy <= 1'b0;
            idx  <= '0;
            sub  <= 8'h00;
        end else if (start_i && !busy) begin
            data <= data_i;
            busy <= 1'b1;
            idx  <= '0;
            sub  <= data_i[7:0];
        end else if (busy) begin
            if (last) begin
                busy <= 1'b0;
            end else begin
                idx <= idx_nxt;
                sub <= data[int'(idx_nxt)*8 +: 8];
            end
        end
    end

    assign sbox_sub_o   = sub;
    assign byte_valid_o = busy;
    assign byte_idx_o   = idx;
    assign done_o       = busy && last;
    assign byte_o       = EXTERNAL_SBOX ? sbox_sub_i : (ENCRYPT ? fwd_sbox(sub) : inv_sbox(sub));
endmodule

module aes128_inv_key_expansion #(
    parameter bit EXTERNAL_SBOX = 1'b0
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [127:0] key_i,
    input  logic         start_i,
    input  logic         key_req_i,
    output logic [127:0] key_o,
    output logic [127:0] key_big_end_o,
    output logic [3:0]   round_o,
    output logic         valid_o,
    output logic [7:0]   sbox_sub_o,
    input  logic [7:0]   sbox_sub_i
);
    typedef enum logic [2:0] {WAIT, XOR, ROT, SUB, RCON, XOR0, DONE} state_t;

    state_t       state;
    logic [127:0] working_key;
    logic [31:0]  manip;
    logic [7:0]   rcon;
    logic [3:0]   round;
    logic         valid;
    logic         sub_start;
`ifndef AES128_INV_KEY_PARALLEL_XOR_EN
    logic [1:0]   cnt;
`endif

    logic         sb_vld;
    logic [1:0]   sb_idx;
    logic [7:0]   sb_byte;
    logic         sb_done;

    function automatic logic [127:0] byte_rev(input logic [127:0] k);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = k[(15-i)*8 +: 8];
        return r;
    endfunction

    aes128_sub_bytes #(
        .N_BYTES       (4),
        .ENCRYPT       (1'b1),
        .EXTERNAL_SBOX (EXTERNAL_SBOX)
    ) u_sub_bytes (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .start_i      (sub_start),
        .data_i       (manip),
        .byte_valid_o (sb_vld),
        .byte_idx_o   (sb_idx),
        .byte_o       (sb_byte),
        .done_o       (sb_done),
        .sbox_sub_o   (sbox_sub_o),
        .sbox_sub_i   (sbox_sub_i)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state       <= WAIT;
            working_key <= '0;
            manip       <= '0;
            rcon        <= 8'h00;
            round       <= 4'd0;
            valid       <= 1'b0;
            sub_start   <= 1'b0;
`ifndef AES128_INV_KEY_PARALLEL_XOR_EN
            cnt         <= 2'd0;
`endif
        end else begin
            unique case (state)
                WAIT: begin
                    if (start_i) begin
                        working_key <= byte_rev(key_i);
                        round       <= 4'd10;
                        valid       <= 1'b1;
                        rcon        <= 8'h36;
                    end else if (key_req_i && valid && round != 4'd0) begin
                        valid <= 1'b0;
                        state <= XOR;
`ifndef AES128_INV_KEY_PARALLEL_XOR_EN
                        cnt   <= 2'd3;
`endif
                    end
                end
                XOR: begin
`ifdef AES128_INV_KEY_PARALLEL_XOR_EN
                    working_key[127:32] <= {working_key[127:96] ^ working_key[95:64],
                                            working_key[95:64]  ^ working_key[63:32],
                                            working_key[63:32]  ^ working_key[31:0]};
                    state <= ROT;
`else
                    // top-down order so each word still sees its unmodified lower neighbour
                    working_key[int'(cnt)*32 +: 32] <= working_key[int'(cnt)*32 +: 32]
                                                     ^ working_key[(int'(cnt)-1)*32 +: 32];
                    cnt <= cnt - 2'd1;
                    if (cnt == 2'd1) state <= ROT;
`endif
                end
                ROT: begin
                    manip     <= {working_key[103:96], working_key[127:104]};
                    sub_start <= 1'b1;
                    state     <= SUB;
                end
                SUB: begin
                    sub_start <= 1'b0;
                    if (sb_vld) manip[int'(sb_idx)*8 +: 8] <= sb_byte;
                    if (sb_done) state <= RCON;
                end
                RCON: begin
                    manip[7:0] <= manip[7:0] ^ rcon;
                    state      <= XOR0;
                end
                XOR0: begin
                    working_key[31:0] <= working_key[31:0] ^ manip;
                    state             <= DONE;
                end
                DONE: begin
                    valid <= 1'b1;
                    round <= round - 4'd1;
                    rcon  <= rcon[0] ? (((rcon ^ 8'h1b) >> 1) | 8'h80) : (rcon >> 1);
                    state <= WAIT;
                end
                default: state <= WAIT;
            endcase
        end
    end

    assign key_o         = working_key;
    assign key_big_end_o = byte_rev(working_key);
    assign round_o       = round;
    assign valid_o       = valid;
endmodule

// File: tb/tb_aes128_inv_key_expansion.sv
// Drives an internal-S-box and an external-S-box instance in lockstep and checks them against a forward key-expansion model.
module tb_aes128_inv_key_expansion;
`ifdef AES128_INV_KEY_PARALLEL_XOR_EN
    localparam int XOR_CYC = 1;
`else
    localparam int XOR_CYC = 3;
`endif
    localparam int SUB_CYC = 5;
    localparam int LAT     = XOR_CYC + 1 + SUB_CYC + 1 + 1 + 1;

    localparam logic [127:0] F_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] F_R9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] F_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] F_R0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] Z_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] Z_R1  = 128'h62636363626363636263636362636363;

    logic         clk = 1'b0;
    logic         rst_n, start, key_req;
    logic [127:0] key_in;
    logic [127:0] ko_a, kbe_a, ko_b, kbe_b;
    logic [3:0]   round_a, round_b;
    logic         valid_a, valid_b;
    logic [7:0]   so_a, so_b, si_a, si_b;

    logic [7:0]   sbox [256];
    logic [127:0] ref_rk [11];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign si_a = 8'h00;
    assign si_b = sbox[so_b];

    aes128_inv_key_expansion #(.EXTERNAL_SBOX(1'b0)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .key_i(key_in), .start_i(start), .key_req_i(key_req),
        .key_o(ko_a), .key_big_end_o(kbe_a), .round_o(round_a), .valid_o(valid_a),
        .sbox_sub_o(so_a), .sbox_sub_i(si_a));

    aes128_inv_key_expansion #(.EXTERNAL_SBOX(1'b1)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .key_i(key_in), .start_i(start), .key_req_i(key_req),
        .key_o(ko_b), .key_big_end_o(kbe_b), .round_o(round_b), .valid_o(valid_b),
        .sbox_sub_o(so_b), .sbox_sub_i(si_b));

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] rl(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [127:0] brev(input logic [127:0] k);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = k[(15-i)*8 +: 8];
        return r;
    endfunction

    // S-box by walking generator 3 and its inverse around the multiplicative group
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
    endtask

    // Standard forward expansion; ref_rk[r] holds round key r big-endian
    task automatic expand(input logic [127:0] k0);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k0[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
                t[31:24] = t[31:24] ^ rc;
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check_key(input string tag, input logic [127:0] exp_be, input int exp_round);
        chk({tag, "_kbe_a"}, kbe_a, exp_be);
        chk({tag, "_kbe_b"}, kbe_b, exp_be);
        chk({tag, "_ko_a"}, ko_a, brev(exp_be));
        chk({tag, "_round_a"}, {124'd0, round_a}, exp_round[127:0]);
        chk({tag, "_round_b"}, {124'd0, round_b}, exp_round[127:0]);
        chk({tag, "_valid"}, {126'd0, valid_a, valid_b}, 128'd3);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_kbe"}, kbe_a | kbe_b, 128'd0);
        chk({tag, "_ko"}, ko_a | ko_b, 128'd0);
        chk({tag, "_round"}, {120'd0, round_a, round_b}, 128'd0);
        chk({tag, "_valid"}, {126'd0, valid_a, valid_b}, 128'd0);
        chk({tag, "_sbox_sub"}, {112'd0, so_a, so_b}, 128'd0);
    endtask

    // All drive tasks are entered right after a falling edge
    task automatic do_start(input logic [127:0] k);
        start  = 1'b1;
        key_in = k;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_valid(input int n0, output int la, output int lb);
        int n;
        n  = n0;
        la = 0;
        lb = 0;
        while (n < 200 && !(valid_a && valid_b)) begin
            @(negedge clk);
            n++;
            if (valid_a && la == 0) la = n;
            if (valid_b && lb == 0) lb = n;
        end
    endtask

    task automatic step(input string tag);
        int la, lb;
        key_req = 1'b1;
        @(negedge clk);
        key_req = 1'b0;
        chk({tag, "_vfall"}, {126'd0, valid_a, valid_b}, 128'd0);
        wait_valid(0, la, lb);
        chk({tag, "_lat_a"}, la, LAT);
        chk({tag, "_lat_b"}, lb, LAT);
    endtask

    typedef struct {
        logic [127:0] k10;
        int           rnd;
        logic [127:0] exp;
    } vec_t;

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt [5];
        int la, lb;
        logic [127:0] k0;

        vt[0] = '{k10: Z_R10, rnd: 1, exp: Z_R1};
        vt[1] = '{k10: Z_R10, rnd: 0, exp: 128'd0};
        vt[2] = '{k10: F_R10, rnd: 9, exp: F_R9};
        vt[3] = '{k10: F_R10, rnd: 1, exp: F_R1};
        vt[4] = '{k10: F_R10, rnd: 0, exp: F_R0};

        rst_n = 1'b0; start = 1'b0; key_req = 1'b0; key_in = '0;
        build_sbox();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_zero("reset");

        key_req = 1'b1;
        @(negedge clk);
        key_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("unloaded_req_valid", {126'd0, valid_a, valid_b}, 128'd0);

        do_start(F_R10);
        check_key("load", F_R10, 10);
        step("r9");
        check_key("r9", F_R9, 9);

        foreach (vt[v]) begin
            do_start(vt[v].k10);
            for (int r = 9; r >= vt[v].rnd; r--) step($sformatf("vec%0d_r%0d", v, r));
            check_key($sformatf("vec%0d", v), vt[v].exp, vt[v].rnd);
        end

        key_req = 1'b1;
        @(negedge clk);
        key_req = 1'b0;
        chk("r0_req_valid", {126'd0, valid_a, valid_b}, 128'd3);
        repeat (15) @(negedge clk);
        check_key("r0_hold", F_R0, 0);

        // start and request arriving mid-step are both dropped
        do_start(F_R10);
        key_req = 1'b1;
        @(negedge clk);
        key_req = 1'b0;
        repeat (5) @(negedge clk);
        key_req = 1'b1;
        start   = 1'b1;
        key_in  = 128'h0123456789abcdeffedcba9876543210;
        @(negedge clk);
        key_req = 1'b0;
        start   = 1'b0;
        wait_valid(6, la, lb);
        chk("midreq_lat_a", la, LAT);
        chk("midreq_lat_b", lb, LAT);
        check_key("midreq", F_R9, 9);
        repeat (15) @(negedge clk);
        check_key("midreq_hold", F_R9, 9);

        start   = 1'b1;
        key_req = 1'b1;
        key_in  = F_R10;
        @(negedge clk);
        start   = 1'b0;
        key_req = 1'b0;
        check_key("simul", F_R10, 10);
        repeat (15) @(negedge clk);
        check_key("simul_hold", F_R10, 10);

        key_req = 1'b1;
        @(negedge clk);
        key_req = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("midrst");
        rst_n = 1'b1;
        @(negedge clk);
        do_start(F_R10);
        for (int r = 9; r >= 0; r--) step($sformatf("post_rst_r%0d", r));
        check_key("post_rst_r0", F_R0, 0);

        for (int t = 0; t < 4; t++) begin
            k0 = {$urandom, $urandom, $urandom, $urandom};
            expand(k0);
            do_start(ref_rk[10]);
            check_key($sformatf("rand%0d_load", t), ref_rk[10], 10);
            for (int r = 9; r >= 0; r--) begin
                step($sformatf("rand%0d_r%0d", t, r));
                check_key($sformatf("rand%0d_r%0d", t, r), ref_rk[r], r);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/aes128_inv_key_expansion.md
# aes128_inv_key_expansion

Inverse AES-128 key schedule for the decryption datapath. It is loaded with the round-10 key and steps backwards one round key per request: round 10 → 9 → … → 0. It computes each earlier key on the fly from the current one, so no round keys are stored. The S-box is shared with the cipher core through the same external S-box port style as the forward key expansion.

## Interface
- `EXTERNAL_SBOX`, default 0: 1 routes SubWord through `sbox_sub_o`/`sbox_sub_i`; 0 uses an internal forward S-box.
- `clk_i` input 1: clock. One clock domain.
- `rst_n_i` input 1: reset, synchronous, active-low.
- `key_i` input 128: round-10 key, big-endian (AES byte 0 in bits 127:120).
- `start_i` input 1: load `key_i`.
- `key_req_i` input 1: request the previous round key.
- `key_o` output 128: current round key, byte-reversed (AES byte 0 in bits 7:0).
- `key_big_end_o` output 128: current round key, big-endian.
- `round_o` output 4: round index of the key on `key_o`.
- `valid_o` output 1: key outputs are stable and valid.
- `sbox_sub_o` output 8: byte to substitute (external S-box).
- `sbox_sub_i` input 8: substituted byte (external S-box).

## Operation
- Internal `working_key` is in byte-reversed order. Word `Wn` = `working_key[n*32+:32]`; within a word, AES byte 0 sits in bits 7:0.
- Inverse step, given current words N0..N3:
  - K3 = N3^N2, K2 = N2^N1, K1 = N1^N0.
  - K0 = N0 ^ SubWord(RotWord(K3)) ^ {24'b0, rcon}.
- RotWord moves byte i to position i-1, with byte 0 moving to position 3.
- SubWord always uses the forward S-box. It runs through `aes128_sub_bytes` with N_BYTES=4 in ENCRYPT mode, one byte at a time.
- rcon register:
  - `start_i` loads 0x36.
  - Each completed step applies inverse xtime: if bit0=1, rcon = ((rcon^0x1B)>>1)|0x80; otherwise rcon = rcon>>1.
  - Sequence used: 36, 1B, 80, 40, 20, 10, 08, 04, 02, 01.
- FSM states: WAIT, XOR, ROT, SUB, RCON, XOR0, DONE.
  - WAIT:
    - `start_i` loads the key, sets `round_o`=10, `valid_o`=1, and rcon=0x36.
    - Otherwise, `key_req_i` with `valid_o`=1 and `round_o`≠0 moves to XOR and clears `valid_o`.
  - XOR: computes W3, W2, W1, one word per cycle using a 2-bit counter.
    - Each word uses the still-unmodified lower word.
    - Counter counts 3→1; exits to ROT after W1.
  - ROT: loads manip = RotWord(new W3).
  - SUB: starts sub_bytes on entry and writes each valid byte into manip. Exits on done.
  - RCON: manip ^= rcon.
  - XOR0: W0 ^= manip.
  - DONE: sets `valid_o`=1, decrements `round_o`, advances rcon, then returns to WAIT.

## Timing
- Reset values: `key_o`=0, `key_big_end_o`=0, `round_o`=0, `valid_o`=0, `sbox_sub_o`=0; state=WAIT, rcon=0.
- `start_i` in WAIT: `valid_o`=1 and the key is visible on the next cycle.
- `key_req_i` accepted: `valid_o`=0 on the next cycle.
- `valid_o` returns to 1 after XOR(3) + ROT(1) + SUB(S) + RCON(1) + XOR0(1) + DONE(1) cycles, where S is the sub_bytes latency for 4 bytes.
- `key_o`/`round_o` are held stable whenever `valid_o`=1.
- Boundary conditions:
  - `start_i` and `key_req_i` together in WAIT: start wins; the request is dropped.
  - `start_i` or `key_req_i` outside WAIT: ignored. No queuing.
  - `key_req_i` at `round_o`=0: ignored; `valid_o` stays 1 and the key is unchanged.
  - `key_req_i` while `valid_o`=0 in WAIT (never loaded): ignored.
  - `rst_n_i` low mid-step: all state returns to reset values on that edge. The partial key is discarded.

## Configuration
- `AES128_INV_KEY_PARALLEL_XOR_EN`:
  - Defined: the XOR state lasts a single cycle. K3, K2 and K1 are computed combinationally from the unmodified N words and written together. Latency drops by 2 cycles.
  - Undefined: 3-cycle sequential XOR as described above.
- Results are bit-identical either way.

## Test plan
- Reset, then idle 5 cycles: all outputs 0, `valid_o`=0.
- `start_i` with `key_i`=d014f9a8c9ee2589e13f0cc8b6630ca6: next cycle `valid_o`=1, `round_o`=10, `key_big_end_o` equals `key_i`.
- One `key_req_i`: `valid_o` falls, then rises after the specified latency (check both macro settings) with `key_big_end_o`=ac7766f319fadc2128d12941575c006e and `round_o`=9.
- Ten requests: the round-1 key is a0fafe1788542cb123a339392a6c7605. Round 0 is 2b7e151628aed2a6abf7158809cf4f3c, `round_o`=0. An 11th request is ignored.
- `key_req_i` during SUB, and `start_i`+`key_req_i` together in WAIT: the mid-step request is ignored; the simultaneous case reloads the key with `round_o`=10 and `valid_o` held at 1.
- `rst_n_i` low during SUB with `EXTERNAL_SBOX`=1 and the external S-box model attached: all outputs 0 next cycle. A fresh `start_i` plus 10 requests reproduces the round-0 key.
